// File: rtl/card_mem_arbiter_if.sv
// Card memory access bus: gameplay write, select read, display read and
// the clear-in-progress flag, bundled so the arbiter and its users share one port.
interface card_mem_arbiter_if #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 4
);
  logic              WrReq;
  logic [ADDR_W-1:0] WrLoc;
  logic [DATA_W-1:0] WrData;
  logic              WrAck;
  logic              SelReq;
  logic [ADDR_W-1:0] SelLoc;
  logic [DATA_W-1:0] SelData;
  logic              SelValid;
  logic              DispReq;
  logic [ADDR_W-1:0] DispLoc;
  logic [DATA_W-1:0] DispData;
  logic              DispValid;
  logic              Busy;

  // Requester side.
  modport master (
    output WrReq, WrLoc, WrData, SelReq, SelLoc, DispReq, DispLoc,
    input  WrAck, SelData, SelValid, DispData, DispValid, Busy
  );

  // Arbiter side.
  modport slave (
    input  WrReq, WrLoc, WrData, SelReq, SelLoc, DispReq, DispLoc,
    output WrAck, SelData, SelValid, DispData, DispValid, Busy
  );
endinterface

// File: rtl/card_mem_arbiter.sv
// Card memory (16 x 6) with a single access port shared by the gameplay
// writer, the select reader and the display reader. One grant per cycle,
// fixed priority Wr > Sel > Disp, with the display promoted to the top once it
// has been denied STARVE_LIMIT cycles in a row. The memory is cleared
// sequentially after every reset before any request is served.
module card_mem_arbiter #(
  parameter int DATA_W       = 6,
  parameter int ADDR_W       = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic                Clk,
  input logic                Reset,
  card_mem_arbiter_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              wr_ack_q, wr_ack_d;
  logic              sel_valid_q, sel_valid_d;
  logic              disp_valid_q, disp_valid_d;
  logic [DATA_W-1:0] sel_data_q, sel_data_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_elig, sel_elig, disp_elig, promote;
  logic              gnt_wr, gnt_sel, gnt_disp;

  // Arbitration: a requester whose ack is high this cycle sits out, so each
  // one needs at least two cycles per access and cannot be double-served.
  always_comb begin
    wr_elig   = bus.WrReq   & ~wr_ack_q;
    sel_elig  = bus.SelReq  & ~sel_valid_q;
    disp_elig = bus.DispReq & ~disp_valid_q;
    promote   = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
    gnt_wr    = 1'b0;
    gnt_sel   = 1'b0;
    gnt_disp  = 1'b0;
    if (state_q == ST_RUN) begin
      if (promote && disp_elig) gnt_disp = 1'b1;
      else if (wr_elig)         gnt_wr   = 1'b1;
      else if (sel_elig)        gnt_sel  = 1'b1;
      else if (disp_elig)       gnt_disp = 1'b1;
    end
  end

  // Next-state: clear sequencing, memory port steering, read capture, starvation count.
  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    wr_ack_d     = gnt_wr;
    sel_valid_d  = gnt_sel;
    disp_valid_d = gnt_disp;
    sel_data_d   = sel_data_q;
    disp_data_d  = disp_data_q;
    starve_cnt_d = starve_cnt_q;
    mem_we       = 1'b0;
    mem_waddr    = bus.WrLoc;
    mem_wdata    = bus.WrData;
    case (state_q)
      ST_CLEAR: begin
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = '0;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
      end
      default: begin
        mem_we = gnt_wr;
        // Reads see the array as it was before this cycle's edge.
        if (gnt_sel)  sel_data_d  = mem_q[bus.SelLoc];
        if (gnt_disp) disp_data_d = mem_q[bus.DispLoc];
      end
    endcase
    if (!bus.DispReq || gnt_disp) begin
      starve_cnt_d = '0;
    end else if ((state_q == ST_RUN) && disp_elig && !promote) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Control and output registers; reset restarts the clear and drops any grant.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_CLEAR;
      clr_addr_q   <= '0;
      wr_ack_q     <= 1'b0;
      sel_valid_q  <= 1'b0;
      disp_valid_q <= 1'b0;
      sel_data_q   <= '0;
      disp_data_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      wr_ack_q     <= wr_ack_d;
      sel_valid_q  <= sel_valid_d;
      disp_valid_q <= disp_valid_d;
      sel_data_q   <= sel_data_d;
      disp_data_q  <= disp_data_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Card memory write port; suppressed on the reset edge so an aborted write never lands.
  always_ff @(posedge Clk) begin
    if (mem_we && !Reset) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.WrAck     = wr_ack_q;
  assign bus.SelValid  = sel_valid_q;
  assign bus.SelData   = sel_data_q;
  assign bus.DispValid = disp_valid_q;
  assign bus.DispData  = disp_data_q;
  assign bus.Busy      = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_card_mem_arbiter.sv
// Bench for card_mem_arbiter: directed request sequences; expected responses
// are queued as stimulus is issued and a negedge monitor matches them.
module tb_card_mem_arbiter;
  localparam int DW = 6;
  localparam int AW = 4;
  localparam int SL = 4;

  logic Clk = 1'b0;
  logic Reset;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] wr_q[$];
  logic [DW-1:0] sel_q[$];
  logic [DW-1:0] disp_q[$];
  logic [DW-1:0] sel_e, disp_e;

  card_mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  card_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(SL)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (bus.WrAck === 1'b1) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_ack unexpected pulse got 1 expected 0");
      end else begin
        void'(wr_q.pop_front());
      end
    end
    if (bus.SelValid === 1'b1) begin
      checks++;
      if (sel_q.size() == 0) begin
        errors++;
        $display("FAIL sel_valid unexpected pulse data %h", bus.SelData);
      end else begin
        sel_e = sel_q.pop_front();
        if (bus.SelData !== sel_e) begin
          errors++;
          $display("FAIL sel_data got %h expected %h", bus.SelData, sel_e);
        end
      end
    end
    if (bus.DispValid === 1'b1) begin
      checks++;
      if (disp_q.size() == 0) begin
        errors++;
        $display("FAIL disp_valid unexpected pulse data %h", bus.DispData);
      end else begin
        disp_e = disp_q.pop_front();
        if (bus.DispData !== disp_e) begin
          errors++;
          $display("FAIL disp_data got %h expected %h", bus.DispData, disp_e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Waits for a requester's ack (0=Wr, 1=Sel, 2=Disp), drops its request in
  // the ack cycle and returns the cycle number, or -1 on timeout.
  task automatic wait_valid(input int which, input int budget, output int at);
    logic v;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge Clk);
      #1;
      case (which)
        0:       v = bus.WrAck;
        1:       v = bus.SelValid;
        default: v = bus.DispValid;
      endcase
      if (v === 1'b1) begin
        at = cyc;
        case (which)
          0:       bus.WrReq   = 1'b0;
          1:       bus.SelReq  = 1'b0;
          default: bus.DispReq = 1'b0;
        endcase
        break;
      end
    end
  endtask

  task automatic wr(input logic [AW-1:0] loc, input logic [DW-1:0] data);
    int t0, at;
    bus.WrReq = 1'b1; bus.WrLoc = loc; bus.WrData = data;
    wr_q.push_back(data);
    t0 = cyc;
    wait_valid(0, 8, at);
    chk("wr_latency", at, t0 + 1);
    bus.WrReq = 1'b0;
    step(1);
  endtask

  task automatic sel_read(input logic [AW-1:0] loc, input logic [DW-1:0] exp);
    int t0, at;
    bus.SelReq = 1'b1; bus.SelLoc = loc;
    sel_q.push_back(exp);
    t0 = cyc;
    wait_valid(1, 8, at);
    chk("sel_latency", at, t0 + 1);
    bus.SelReq = 1'b0;
    step(1);
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
  endtask

  // Counts consecutive Busy cycles starting with the current one.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Busy !== 1'b1) break;
      n++;
      step(1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0, r0, nb, aw, as, ad;
    logic [5:0] pat;
    Reset = 1'b1;
    bus.WrReq = 1'b0; bus.WrLoc = '0; bus.WrData = '0;
    bus.SelReq = 1'b0; bus.SelLoc = '0;
    bus.DispReq = 1'b0; bus.DispLoc = '0;
    step(2);

    // Clear after reset with a write already waiting.
    Reset = 1'b0;
    bus.WrReq = 1'b1; bus.WrLoc = 4'd3; bus.WrData = 6'h15;
    wr_q.push_back(6'h15);
    r0 = cyc;
    chk("rst_busy", bus.Busy, 1);
    chk("rst_wr_ack", bus.WrAck, 0);
    chk("rst_sel_valid", bus.SelValid, 0);
    chk("rst_disp_valid", bus.DispValid, 0);
    chk("rst_sel_data", bus.SelData, 0);
    chk("rst_disp_data", bus.DispData, 0);
    chk("rst_starve_cnt", dut.starve_cnt_q, 0);
    chk("rst_clr_addr", dut.clr_addr_q, 0);
    count_busy(nb);
    chk("clear_busy_cycles", nb, 16);
    wait_valid(0, 4, aw);
    chk("clear_wr_ack_cycle", aw, r0 + 17);
    step(1);
    for (int i = 0; i < 16; i++) sel_read(4'(i), (i == 3) ? 6'h15 : 6'h00);

    // Write then read back; data register holds after the pulse.
    wr(4'd7, 6'h12);
    sel_read(4'd7, 6'h12);
    step(2);
    chk("sel_data_held", bus.SelData, 6'h12);
    chk("sel_valid_low", bus.SelValid, 0);

    // All three request together: Wr, then Sel, then Disp.
    bus.WrReq = 1'b1; bus.WrLoc = 4'd9; bus.WrData = 6'h2a;
    bus.SelReq = 1'b1; bus.SelLoc = 4'd7;
    bus.DispReq = 1'b1; bus.DispLoc = 4'd3;
    wr_q.push_back(6'h2a); sel_q.push_back(6'h12); disp_q.push_back(6'h15);
    t0 = cyc;
    fork
      wait_valid(0, 6, aw);
      wait_valid(1, 6, as);
      wait_valid(2, 6, ad);
    join
    chk("prio_wr_ack", aw, t0 + 1);
    chk("prio_sel_valid", as, t0 + 2);
    chk("prio_disp_valid", ad, t0 + 3);
    step(2);
    chk("disp_data_held", bus.DispData, 6'h15);

    // Starvation: Wr and Sel never let go; Disp must get promoted.
    bus.WrReq = 1'b1; bus.WrLoc = 4'd10; bus.WrData = 6'h21;
    bus.SelReq = 1'b1; bus.SelLoc = 4'd11;
    bus.DispReq = 1'b1; bus.DispLoc = 4'd10;
    wr_q.push_back(6'h21); wr_q.push_back(6'h21);
    sel_q.push_back(6'h00); sel_q.push_back(6'h00);
    disp_q.push_back(6'h21);
    t0 = cyc;
    wait_valid(2, 10, ad);
    bus.WrReq = 1'b0; bus.SelReq = 1'b0;
    chk("starve_disp_valid", ad, t0 + 5);
    chk("starve_cnt_cleared", dut.starve_cnt_q, 0);
    step(2);
    chk("starve_wr_drained", wr_q.size(), 0);
    chk("starve_sel_drained", sel_q.size(), 0);
    chk("starve_disp_drained", disp_q.size(), 0);

    // Reset in the middle of the clear restarts it from address 0.
    pulse_reset();
    step(9);
    chk("mid_clear_addr", dut.clr_addr_q, 9);
    chk("mid_clear_busy", bus.Busy, 1);
    pulse_reset();
    chk("restart_clr_addr", dut.clr_addr_q, 0);
    count_busy(nb);
    chk("restart_busy_cycles", nb, 16);

    // Reset while a select read is being granted: dropped, then served after clear.
    bus.SelReq = 1'b1; bus.SelLoc = 4'd7;
    pulse_reset();
    chk("abort_sel_valid", bus.SelValid, 0);
    sel_q.push_back(6'h00);
    r0 = cyc;
    count_busy(nb);
    chk("abort_busy_cycles", nb, 16);
    wait_valid(1, 4, as);
    chk("abort_sel_served", as, r0 + 17);
    step(1);

    // Holdoff: a held select request is served every other cycle.
    wr(4'd5, 6'h2c);
    bus.SelReq = 1'b1; bus.SelLoc = 4'd5;
    for (int i = 0; i < 3; i++) sel_q.push_back(6'h2c);
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      pat[i] = bus.SelValid;
    end
    bus.SelReq = 1'b0;
    chk("holdoff_pattern", pat, 6'b010101);
    step(2);

    chk("final_wr_drained", wr_q.size(), 0);
    chk("final_sel_drained", sel_q.size(), 0);
    chk("final_disp_drained", disp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/card_mem_arbiter.md
Name: card_mem_arbiter

Overview:
- Owns the 16-entry x 6-bit card memory and arbitrates its single access port between three requesters.
- Requester 1, gameplay writer: hide, show and remove updates, plus the initial deal.
- Requester 2, select reader: fetches the card under the cursor when the player presses Select.
- Requester 3, display reader: VGA renderer scanning card states.
- Provides one access per cycle with fixed priority, a starvation guard for the display, and a sequential clear of the memory after reset.

Parameters:
- DATA_W, 6: card word width, {state[1:0], value[3:0]}.
- ADDR_W, 4: address width; depth = 2^ADDR_W = 16.
- STARVE_LIMIT, 8: consecutive denied display-request cycles before the display is promoted to top priority.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- WrReq  input  1  gameplay write request, level-held until WrAck.
- WrLoc  input  ADDR_W  write address.
- WrData  input  DATA_W  write data.
- WrAck  output  1  one-cycle pulse: write committed.
- SelReq  input  1  select-read request, level-held until SelValid.
- SelLoc  input  ADDR_W  select-read address.
- SelData  output  DATA_W  select-read data; valid while SelValid is high, held afterwards.
- SelValid  output  1  one-cycle pulse.
- DispReq  input  1  display-read request, level-held until DispValid.
- DispLoc  input  ADDR_W  display-read address.
- DispData  output  DATA_W  display-read data; valid while DispValid is high, held afterwards.
- DispValid  output  1  one-cycle pulse.
- Busy  output  1  high while the clear sequence runs.

Behaviour:
- Clock and reset: one clock, Clk; Reset is synchronous and active-high.
- Reset values, taken at the posedge with Reset high: state=CLEAR, clr_addr=0, WrAck=0, SelValid=0, DispValid=0, SelData=0, DispData=0, starve_cnt=0, Busy=1.
- State CLEAR:
  - Each cycle writes 6'b000000 to mem[clr_addr] and increments clr_addr.
  - After the write to address 15, moves to RUN; the clear takes 16 cycles.
  - Busy=1 throughout CLEAR. No requests are granted and all acks stay 0; requests stay pending.
- State RUN: at most one grant per cycle, decided combinationally from the current-cycle requests.
  - Eligible requester: its request is high and its ack/valid output is not high this cycle. This ack-cycle holdoff means each requester's minimum turnaround is 2 cycles.
  - Priority when starve_cnt < STARVE_LIMIT: Wr > Sel > Disp.
  - Priority when starve_cnt == STARVE_LIMIT: Disp > Wr > Sel.
- Access timing:
  - Write grant in cycle N: mem[WrLoc] <= WrData at the end of N; WrAck=1 in N+1.
  - Read grant in cycle N: the data register <= mem[loc] at the end of N; the matching valid=1 in N+1. Read latency is 1 cycle.
  - Reads return the memory content before any write in the same cycle. Same-cycle read and write cannot occur because there is a single grant.
- starve_cnt:
  - Increments each RUN cycle in which Disp is eligible and not granted; saturates at STARVE_LIMIT.
  - Resets to 0 on a Disp grant, and when DispReq is low.
- Back-to-back writes: WrReq held high continuously is granted every other cycle (N, N+2, ...). A write to the same location as a pending read takes effect before that read is granted if Wr wins priority.
- Reset mid-operation (RUN or CLEAR): returns to CLEAR with clr_addr=0. Any pending grant is discarded with no ack, and the full 16-cycle clear restarts.
- Address and data are sampled only in the grant cycle; changes while ungranted are harmless.

Test Plan:
- Clear: assert Reset for 1 cycle, then hold WrReq=1 (WrLoc=3, WrData=6'h15). Expect Busy=1 for exactly 16 cycles, WrAck in cycle 18 after reset release, and SelReq(loc 0..15) reads 0 everywhere except 6'h15 at loc 3.
- Write then read: write 6'h12 to loc 7; after WrAck, SelReq loc 7. Expect SelValid 1 cycle after grant with SelData=6'h12, and SelData held after the pulse.
- Priority: WrReq, SelReq and DispReq rise together in RUN. Expect grants Wr at cycle N, Sel at N+1, Disp at N+2, and acks at N+1, N+2, N+3 respectively.
- Starvation (STARVE_LIMIT=4): hold WrReq and SelReq high continuously with DispReq high. Expect DispValid no later than 6 cycles after DispReq rises, and starve_cnt back at 0 after the grant.
- Reset mid-clear and mid-request: pulse Reset at clear cycle 9, and again while SelReq is pending in RUN. Expect clr_addr restarting at 0, a full 16-cycle Busy, no SelValid from the aborted request, and the request served after the clear.
- Holdoff: hold SelReq high for 6 cycles alone in RUN. Expect SelValid pulses every other cycle (3 pulses), never two consecutive.
